udp_tx_sched: RTL and testbench

- Round-robin scheduler sharing the single UDP transmit path between N_SRC send sockets.
- Each socket owns a byte FIFO holding one pending datagram payload and presents a request with length and destination.
- The scheduler picks one socket, latches its header fields and streams exactly req_len bytes from that socket's FIFO onto the UDP TX byte interface with sof/eof framing.
- Oversize requests are drained from the FIFO and dropped, never forwarded.

---
 rtl/udp_tx_sched.sv | 158 +++++++++++++++
 tb/tb_udp_tx_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler sharing one UDP TX byte path between N_SRC sockets.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   my_port                      - source port stamped on every datagram
//   req_valid/len/dst_port/ip    - per-socket request (packed, socket i at slice i)
//   fifo_rd / fifo_din           - per-socket FIFO read strobe / data (1-cycle latency)
//   grant, done, drop            - per-datagram status pulses
//   m_udp_*                      - latched header and framed payload byte stream
//   m_udp_ready                  - TX engine flow control (tolerates 2 bytes in flight)
module udp_tx_sched #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned MAX_LEN = 1472
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           my_port,
  input  logic [N_SRC-1:0]      req_valid,
  input  logic [16*N_SRC-1:0]   req_len,
  input  logic [16*N_SRC-1:0]   req_dst_port,
  input  logic [32*N_SRC-1:0]   req_dst_ip,
  output logic [N_SRC-1:0]      fifo_rd,
  input  logic [8*N_SRC-1:0]    fifo_din,
  output logic [N_SRC-1:0]      grant,
  output logic [N_SRC-1:0]      done,
  output logic                  drop,
  output logic [15:0]           m_udp_src_port,
  output logic [15:0]           m_udp_dst_port,
  output logic [31:0]           m_udp_dst_ip,
  output logic [15:0]           m_udp_len,
  output logic [7:0]            m_udp_dout,
  output logic                  m_udp_sof,
  output logic                  m_udp_eof,
  output logic                  m_udp_valid,
  input  logic                  m_udp_ready
);

  localparam int unsigned SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [5:0] {
    S_IDLE   = 6'd0,
    S_ARB    = 6'd10,
    S_STREAM = 6'd20,
    S_DRAIN  = 6'd30,
    S_DONE   = 6'd40
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   rr_ptr, sel, pick, arb_idx;
  logic               pick_found;
  logic [15:0]        pick_len;
  logic [15:0]        rd_cnt, out_cnt;
  logic               rd_d1, drained;
  logic               rd_stream, rd_drain, rd_now;

  // Round-robin search starting just after the last granted socket
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    arb_idx    = '0;
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      arb_idx = SEL_W'((32'(rr_ptr) + i) % N_SRC);
      if (!pick_found && req_valid[arb_idx]) begin
        pick       = arb_idx;
        pick_found = 1'b1;
      end
    end
  end

  assign pick_len  = req_len[16*pick +: 16];
  assign rd_stream = (state == S_STREAM) && m_udp_ready && (rd_cnt < m_udp_len);
  assign rd_drain  = (state == S_DRAIN) && (rd_cnt < m_udp_len);
  assign rd_now    = rd_stream || rd_drain;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = (|req_valid) ? S_ARB : S_IDLE;
      S_ARB: begin
        if (!pick_found)                 state_nxt = S_IDLE;
        else if (pick_len == 16'd0)      state_nxt = S_DONE;
        else if (pick_len > 16'(MAX_LEN)) state_nxt = S_DRAIN;
        else                             state_nxt = S_STREAM;
      end
      // Leave once the eof byte is on the output
      S_STREAM: state_nxt = (m_udp_valid && m_udp_eof) ? S_DONE : S_STREAM;
      // All reads issued and the final byte has already returned
      S_DRAIN:  state_nxt = (rd_cnt == m_udp_len) ? S_DONE : S_DRAIN;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode; every strobe is one-hot on the current socket
  always_comb begin
    fifo_rd = '0;
    grant   = '0;
    done    = '0;
    drop    = 1'b0;
    if (rd_now) fifo_rd = N_SRC'(1) << sel;
    if ((state == S_ARB) && pick_found) grant = N_SRC'(1) << pick;
    if (state == S_DONE) begin
      done = N_SRC'(1) << sel;
      drop = drained;
    end
  end

  // Header latch, read counting and the two-stage read-to-output pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= SEL_W'(N_SRC - 1);
      sel            <= '0;
      drained        <= 1'b0;
      rd_cnt         <= '0;
      out_cnt        <= '0;
      rd_d1          <= 1'b0;
      m_udp_src_port <= '0;
      m_udp_dst_port <= '0;
      m_udp_dst_ip   <= '0;
      m_udp_len      <= '0;
      m_udp_dout     <= '0;
      m_udp_sof      <= 1'b0;
      m_udp_eof      <= 1'b0;
      m_udp_valid    <= 1'b0;
    end else begin
      if ((state == S_ARB) && pick_found) begin
        sel            <= pick;
        rr_ptr         <= pick;
        drained        <= (pick_len > 16'(MAX_LEN));
        m_udp_src_port <= my_port;
        m_udp_dst_port <= req_dst_port[16*pick +: 16];
        m_udp_dst_ip   <= req_dst_ip[32*pick +: 32];
        m_udp_len      <= pick_len;
      end
      if (rd_now) rd_cnt <= rd_cnt + 16'd1;
      // Only streamed reads feed the output; drained bytes are discarded
      rd_d1       <= rd_stream;
      m_udp_valid <= rd_d1;
      m_udp_sof   <= rd_d1 && (out_cnt == 16'd0);
      m_udp_eof   <= rd_d1 && (out_cnt == m_udp_len - 16'd1);
      if (rd_d1) begin
        m_udp_dout <= fifo_din[8*sel +: 8];
        out_cnt    <= out_cnt + 16'd1;
      end
      if (state == S_DONE) begin
        rd_cnt  <= '0;
        out_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed testbench for udp_tx_sched with a per-socket FIFO model and monitor.
module tb_udp_tx_sched;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   my_port;
  logic [N-1:0]  req_valid;
  logic [16*N-1:0] req_len, req_dst_port;
  logic [32*N-1:0] req_dst_ip;
  logic [N-1:0]  fifo_rd, grant, done;
  logic [8*N-1:0] fifo_din;
  logic          drop;
  logic [15:0]   m_udp_src_port, m_udp_dst_port, m_udp_len;
  logic [31:0]   m_udp_dst_ip;
  logic [7:0]    m_udp_dout;
  logic          m_udp_sof, m_udp_eof, m_udp_valid, m_udp_ready;

  udp_tx_sched #(.N_SRC(N), .MAX_LEN(1472)) dut (
    .clk(clk), .rst_n(rst_n), .my_port(my_port),
    .req_valid(req_valid), .req_len(req_len), .req_dst_port(req_dst_port),
    .req_dst_ip(req_dst_ip), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
    .grant(grant), .done(done), .drop(drop),
    .m_udp_src_port(m_udp_src_port), .m_udp_dst_port(m_udp_dst_port),
    .m_udp_dst_ip(m_udp_dst_ip), .m_udp_len(m_udp_len), .m_udp_dout(m_udp_dout),
    .m_udp_sof(m_udp_sof), .m_udp_eof(m_udp_eof), .m_udp_valid(m_udp_valid),
    .m_udp_ready(m_udp_ready)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // FIFO content: byte k of socket s's datagram
  function automatic logic [7:0] pat(input int s, input int k);
    return 8'(s * 37 + k * 5 + 3);
  endfunction

  // FIFO model: pointer restarts on grant, data returns one cycle after a read
  int ptr [N];
  initial fifo_din = '0;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (grant[i]) ptr[i] <= 0;
      else if (fifo_rd[i]) begin
        fifo_din[i*8 +: 8] <= pat(i, ptr[i]);
        ptr[i] <= ptr[i] + 1;
      end
    end
  end

  // Monitor: logs activity, sampled on the falling edge
  int            rd_cnt [N];
  int            grant_log [$];
  logic [9:0]    byte_q [$];
  int            done_cnt = 0, drop_cnt = 0, drop_done_cnt = 0, onehot_viol = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (fifo_rd[i]) rd_cnt[i]++;
        if (grant[i]) grant_log.push_back(i);
        if (done[i]) done_cnt++;
      end
      if (drop) drop_cnt++;
      if (drop && (done != '0)) drop_done_cnt++;
      if (m_udp_valid) byte_q.push_back({m_udp_sof, m_udp_eof, m_udp_dout});
      if (!$onehot0(fifo_rd) || !$onehot0(grant) || !$onehot0(done)) onehot_viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Snapshots of the monitor state at the start of each step
  int b0, g0, d0, dr0, dd0;
  int rc0 [N];
  task automatic mark();
    b0 = byte_q.size(); g0 = grant_log.size();
    d0 = done_cnt; dr0 = drop_cnt; dd0 = drop_done_cnt;
    for (int i = 0; i < N; i++) rc0[i] = rd_cnt[i];
  endtask

  task automatic set_req(input int s, input int len, input logic [15:0] port,
                         input logic [31:0] ip);
    req_len[16*s +: 16]      = 16'(len);
    req_dst_port[16*s +: 16] = port;
    req_dst_ip[32*s +: 32]   = ip;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Bounded wait for done on socket s (s<0: any socket)
  task automatic wait_done(input int s, input int max_cyc);
    bit hit = 1'b0;
    for (int c = 0; c < max_cyc && !hit; c++) begin
      @(negedge clk);
      if (s < 0) hit = (done != '0);
      else       hit = done[s];
    end
    chk("done_timeout", 64'(hit), 64'd1);
  endtask

  task automatic settle();
    @(posedge clk); @(negedge clk); @(negedge clk);
  endtask

  logic [7:0] t1_bytes [5];
  int rr_exp [5];
  int nv;

  initial begin
    rst_n = 1'b0; my_port = 16'hBEEF; req_valid = '0; req_len = '0;
    req_dst_port = '0; req_dst_ip = '0; m_udp_ready = 1'b1;
    t1_bytes = '{8'h4D, 8'h52, 8'h57, 8'h5C, 8'h61};
    rr_exp   = '{0, 1, 2, 3, 0};
    #1;
    chk("reset_outputs", {fifo_rd, grant, done, drop, m_udp_valid, m_udp_sof,
         m_udp_eof, m_udp_len, m_udp_dout}, 64'd0);
    do_reset();

    // Single socket, len 5
    mark();
    set_req(2, 5, 16'h1234, 32'hC0A80102);
    req_valid = 4'b0100;
    wait_done(2, 100);
    req_valid = '0;
    settle();
    chk("t1_grant_cnt", 64'(grant_log.size() - g0), 64'd1);
    chk("t1_grant_id", 64'(grant_log[g0]), 64'd2);
    chk("t1_nbytes", 64'(byte_q.size() - b0), 64'd5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t1_byte%0d", k), 64'(byte_q[b0+k]),
          64'({k == 0, k == 4, t1_bytes[k]}));
    chk("t1_len", 64'(m_udp_len), 64'd5);
    chk("t1_dst_port", 64'(m_udp_dst_port), 64'h1234);
    chk("t1_dst_ip", 64'(m_udp_dst_ip), 64'hC0A80102);
    chk("t1_src_port", 64'(m_udp_src_port), 64'hBEEF);
    chk("t1_rd_cnt", 64'(rd_cnt[2] - rc0[2]), 64'd5);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t1_drop_cnt", 64'(drop_cnt - dr0), 64'd0);

    // Round-robin: all sockets request len 3 continuously
    do_reset();
    mark();
    for (int s = 0; s < N; s++) set_req(s, 3, 16'(100 + s), 32'(s));
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) wait_done(-1, 100);
    req_valid = '0;
    settle();
    chk("rr_grant_cnt", 64'(grant_log.size() - g0), 64'd5);
    for (int g = 0; g < 5; g++)
      chk($sformatf("rr_grant%0d", g), 64'(grant_log[g0+g]), 64'(rr_exp[g]));
    chk("rr_nbytes", 64'(byte_q.size() - b0), 64'd15);
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < 3; k++)
        chk($sformatf("rr_byte%0d_%0d", g, k), 64'(byte_q[b0+3*g+k]),
            64'({k == 0, k == 2, pat(rr_exp[g], k)}));

    // Backpressure, len 10, ready pattern 1,0,0 repeating
    mark();
    set_req(1, 10, 16'h0050, 32'h0A000001);
    req_valid = 4'b0010;
    nv = 0;
    for (int c = 0; c < 300 && nv == 0; c++) begin
      @(negedge clk);
      if (done[1]) nv = 1;
      m_udp_ready = (c % 3 == 0);
    end
    chk("bp_done_seen", 64'(nv), 64'd1);
    req_valid = '0; m_udp_ready = 1'b1;
    settle();
    chk("bp_nbytes", 64'(byte_q.size() - b0), 64'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("bp_byte%0d", k), 64'(byte_q[b0+k]),
          64'({k == 0, k == 9, pat(1, k)}));
    chk("bp_rd_cnt", 64'(rd_cnt[1] - rc0[1]), 64'd10);

    // len 1: sof and eof on the same byte
    mark();
    set_req(3, 1, 16'h0001, 32'h01020304);
    req_valid = 4'b1000;
    wait_done(3, 100);
    req_valid = '0;
    settle();
    chk("l1_nbytes", 64'(byte_q.size() - b0), 64'd1);
    chk("l1_byte", 64'(byte_q[b0]), 64'({1'b1, 1'b1, pat(3, 0)}));

    // len 0: grant then done, nothing streamed, no drop
    mark();
    set_req(0, 0, 16'h0002, 32'h05060708);
    req_valid = 4'b0001;
    wait_done(0, 100);
    req_valid = '0;
    settle();
    chk("l0_grant_id", 64'(grant_log[g0]), 64'd0);
    chk("l0_nbytes", 64'(byte_q.size() - b0), 64'd0);
    chk("l0_rd_cnt", 64'(rd_cnt[0] - rc0[0]), 64'd0);
    chk("l0_drop_cnt", 64'(drop_cnt - dr0), 64'd0);
    chk("l0_len", 64'(m_udp_len), 64'd0);

    // Oversize len 1473: drained and dropped
    mark();
    set_req(2, 1473, 16'h0003, 32'h09090909);
    req_valid = 4'b0100;
    wait_done(2, 3000);
    req_valid = '0;
    settle();
    chk("ov_rd_cnt", 64'(rd_cnt[2] - rc0[2]), 64'd1473);
    chk("ov_nbytes", 64'(byte_q.size() - b0), 64'd0);
    chk("ov_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("ov_drop_with_done", 64'(drop_done_cnt - dd0), 64'd1);

    // Async reset at byte 4 of a len-8 stream
    mark();
    set_req(0, 8, 16'h0004, 32'h0B0B0B0B);
    req_valid = 4'b0001;
    nv = 0;
    for (int c = 0; c < 100 && nv < 5; c++) begin
      @(negedge clk);
      if (m_udp_valid) nv++;
    end
    chk("rst_reached_byte4", 64'(nv), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero", {fifo_rd, grant, done, drop, m_udp_valid, m_udp_sof,
         m_udp_eof, m_udp_len, m_udp_dout}, 64'd0);
    chk("rst_header_zero", {m_udp_src_port, m_udp_dst_port, m_udp_dst_ip}, 64'd0);
    set_req(1, 2, 16'h0005, 32'h0C0C0C0C);
    req_valid = 4'b0010;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(1, 100);
    req_valid = '0;
    settle();
    chk("rst_first_grant", 64'(grant_log[g0]), 64'd0);
    chk("rst_post_grant", 64'(grant_log[g0+1]), 64'd1);
    chk("rst_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("rst_nbytes", 64'(byte_q.size() - b0), 64'd7);
    chk("rst_byte4_no_eof", 64'(byte_q[b0+4][8]), 64'd0);
    chk("rst_s1_byte0", 64'(byte_q[b0+5]), 64'({1'b1, 1'b0, pat(1, 0)}));
    chk("rst_s1_byte1", 64'(byte_q[b0+6]), 64'({1'b0, 1'b1, pat(1, 1)}));

    chk("onehot_strobes", 64'(onehot_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
